// File: rtl/pixel_write_arbiter_pkg.sv
// Shared constants for the pixel write path: default coordinate/colour widths,
// palette entries and source indices used by the sprite datapaths.
package pixel_write_arbiter_pkg;

    localparam int DEF_X_W = 7;
    localparam int DEF_Y_W = 7;
    localparam int DEF_C_W = 3;

    localparam logic [DEF_C_W-1:0] COLOR_BLACK = 3'b000;  // erase colour
    localparam logic [DEF_C_W-1:0] COLOR_WHITE = 3'b111;

    localparam int SRC_PLAYER = 0;
    localparam int SRC_BEE0   = 1;

    // Width of an index able to name every source (at least one bit).
    function automatic int src_idx_w(input int num_src);
        return (num_src > 1) ? $clog2(num_src) : 1;
    endfunction

endpackage

// File: rtl/pixel_fifo.sv
// Small per-source pixel queue. Full-and-popped pushes are accepted; flush
// empties the queue synchronously and wins over push and pop.
module pixel_fifo #(
    parameter int W     = 17,
    parameter int DEPTH = 4
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         flush,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic          push_ok, pop_ok;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign dout    = mem[rd_ptr];

    // NOTE: non-blocking (<=) for all clocked state so every register samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // NOTE: storage has no reset; count alone defines which entries are valid, so it maps to plain RAM.
    always_ff @(posedge clk) begin
        if (push_ok && !flush) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/pixel_write_arbiter.sv
// Merges per-sprite pixel write streams into one VGA adapter write port:
// one FIFO per source, round-robin drain of one pixel per clock.
module pixel_write_arbiter
    import pixel_write_arbiter_pkg::*;
#(
    parameter int NUM_SRC    = 2,
    parameter int X_W        = DEF_X_W,
    parameter int Y_W        = DEF_Y_W,
    parameter int C_W        = DEF_C_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   flush,
    input  logic [NUM_SRC*X_W-1:0] src_x,
    input  logic [NUM_SRC*Y_W-1:0] src_y,
    input  logic [NUM_SRC*C_W-1:0] src_color,
    input  logic [NUM_SRC-1:0]     src_we,
    output logic [X_W-1:0]         x,
    output logic [Y_W-1:0]         y,
    output logic [C_W-1:0]         colour,
    output logic                   plot,
    output logic [NUM_SRC-1:0]     drop,
    output logic [NUM_SRC-1:0]     pending
);

    localparam int DW = X_W + Y_W + C_W;
    localparam int GW = src_idx_w(NUM_SRC);

    logic [DW-1:0]      head [NUM_SRC];
    logic [NUM_SRC-1:0] full, empty, pop;
    logic [GW-1:0]      last_grant, grant_idx;
    logic               grant_valid;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_src
        pixel_fifo #(.W(DW), .DEPTH(FIFO_DEPTH)) u_fifo (
            .clk     (clk),
            .reset_n (reset_n),
            .flush   (flush),
            .push    (src_we[i]),
            .pop     (pop[i]),
            .din     ({src_x[i*X_W +: X_W], src_y[i*Y_W +: Y_W], src_color[i*C_W +: C_W]}),
            .dout    (head[i]),
            .full    (full[i]),
            .empty   (empty[i])
        );
        assign pop[i] = grant_valid && (grant_idx == GW'(i)) && !flush;
    end

    assign pending = ~empty;

    // Search from the source after the last winner, wrapping modulo NUM_SRC.
    // NOTE: defaults are assigned first so no path through the loop infers a latch.
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int k = 1; k <= NUM_SRC; k++) begin
            int idx;
            idx = (int'(last_grant) + k) % NUM_SRC;
            if (!grant_valid && !empty[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = GW'(idx);
            end
        end
    end

    // Pointer starts at the last source so the player wins the first grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x          <= '0;
            y          <= '0;
            colour     <= '0;
            plot       <= 1'b0;
            drop       <= '0;
            last_grant <= GW'(NUM_SRC - 1);
        end else if (flush) begin
            plot <= 1'b0;
            drop <= '0;
        end else begin
            drop <= drop | (src_we & full & ~pop);
            if (grant_valid) begin
                {x, y, colour} <= head[grant_idx];
                plot           <= 1'b1;
                last_grant     <= grant_idx;
            end else begin
                plot <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pixel_write_arbiter.sv
// Self-checking bench: directed scenarios plus random traffic, all compared
// against a queue-based reference model of the merged write stream.
module tb_pixel_write_arbiter;

    localparam int NUM_SRC = 2;
    localparam int X_W     = 7;
    localparam int Y_W     = 7;
    localparam int C_W     = 3;
    localparam int DEPTH   = 4;
    localparam int DW      = X_W + Y_W + C_W;

    logic                   clk = 1'b0;
    logic                   reset_n;
    logic                   flush;
    logic [NUM_SRC*X_W-1:0] src_x;
    logic [NUM_SRC*Y_W-1:0] src_y;
    logic [NUM_SRC*C_W-1:0] src_color;
    logic [NUM_SRC-1:0]     src_we;
    logic [X_W-1:0]         x;
    logic [Y_W-1:0]         y;
    logic [C_W-1:0]         colour;
    logic                   plot;
    logic [NUM_SRC-1:0]     drop;
    logic [NUM_SRC-1:0]     pending;

    pixel_write_arbiter #(
        .NUM_SRC(NUM_SRC), .X_W(X_W), .Y_W(Y_W), .C_W(C_W), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .reset_n(reset_n), .flush(flush),
        .src_x(src_x), .src_y(src_y), .src_color(src_color), .src_we(src_we),
        .x(x), .y(y), .colour(colour), .plot(plot), .drop(drop), .pending(pending)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: one queue per source, pointer to the last winner.
    logic [DW-1:0]      q [NUM_SRC][$];
    int                 m_last;
    logic [X_W-1:0]     m_x;
    logic [Y_W-1:0]     m_y;
    logic [C_W-1:0]     m_c;
    logic               m_plot;
    logic [NUM_SRC-1:0] m_drop;

    task automatic model_reset();
        for (int i = 0; i < NUM_SRC; i++) q[i].delete();
        m_last = NUM_SRC - 1;
        m_x = '0; m_y = '0; m_c = '0; m_plot = 1'b0; m_drop = '0;
    endtask

    task automatic model_step();
        int g;
        if (flush) begin
            for (int i = 0; i < NUM_SRC; i++) q[i].delete();
            m_drop = '0;
            m_plot = 1'b0;
        end else begin
            g = -1;
            for (int k = 1; k <= NUM_SRC; k++)
                if (g < 0 && q[(m_last + k) % NUM_SRC].size() > 0) g = (m_last + k) % NUM_SRC;
            if (g >= 0) begin
                {m_x, m_y, m_c} = q[g].pop_front();
                m_plot = 1'b1;
                m_last = g;
            end else begin
                m_plot = 1'b0;
            end
            for (int i = 0; i < NUM_SRC; i++)
                if (src_we[i]) begin
                    if (q[i].size() < DEPTH)
                        q[i].push_back({src_x[i*X_W +: X_W], src_y[i*Y_W +: Y_W], src_color[i*C_W +: C_W]});
                    else
                        m_drop[i] = 1'b1;
                end
        end
    endtask

    task automatic compare_all();
        logic [NUM_SRC-1:0] m_pend;
        for (int i = 0; i < NUM_SRC; i++) m_pend[i] = (q[i].size() > 0);
        check("plot", 32'(plot), 32'(m_plot));
        check("x", 32'(x), 32'(m_x));
        check("y", 32'(y), 32'(m_y));
        check("colour", 32'(colour), 32'(m_c));
        check("drop", 32'(drop), 32'(m_drop));
        check("pending", 32'(pending), 32'(m_pend));
    endtask

    // Inputs are already set away from the edge; step model, clock, then compare.
    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic set_src(input int i, input logic we, input int px, input int py, input int pc);
        src_we[i]                = we;
        src_x[i*X_W +: X_W]      = X_W'(px);
        src_y[i*Y_W +: Y_W]      = Y_W'(py);
        src_color[i*C_W +: C_W]  = C_W'(pc);
    endtask

    task automatic idle_inputs();
        flush = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) set_src(i, 1'b0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        idle_inputs();
        @(negedge clk);
        model_reset();
        #1;
        compare_all();
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        idle_inputs();
        model_reset();

        // Reset state
        do_reset();
        check("rst_plot", 32'(plot), 0);
        check("rst_drop", 32'(drop), 0);

        // Single source: push at edge 1, visible only after edge 2
        set_src(0, 1'b1, 10, 20, 7);
        tick();
        check("single_edge1_plot", 32'(plot), 0);
        check("single_edge1_pend", 32'(pending), 1);
        set_src(0, 1'b0, 0, 0, 0);
        tick();
        check("single_plot", 32'(plot), 1);
        check("single_x", 32'(x), 10);
        check("single_y", 32'(y), 20);
        check("single_c", 32'(colour), 7);
        check("single_drop", 32'(drop), 0);
        tick();
        check("single_after_plot", 32'(plot), 0);
        check("single_hold_x", 32'(x), 10);

        // Simultaneous writes after reset: src0 first, then src1
        do_reset();
        set_src(0, 1'b1, 1, 1, 1);
        set_src(1, 1'b1, 2, 2, 2);
        tick();
        idle_inputs();
        tick();
        check("simul_first_x", 32'(x), 1);
        check("simul_first_c", 32'(colour), 1);
        tick();
        check("simul_second_x", 32'(x), 2);
        check("simul_second_c", 32'(colour), 2);
        tick();
        check("simul_idle_plot", 32'(plot), 0);

        // Fairness and saturation: both sources busy for 20 cycles
        for (int n = 0; n < 20; n++) begin
            set_src(0, 1'b1, n, 40, 1);
            set_src(1, 1'b1, n, 80, 2);
            tick();
        end
        check("fair_drop", 32'(drop), 32'h3);
        idle_inputs();
        for (int n = 0; n < 10; n++) tick();

        // Only src1 busy: drains with one cycle lag, never overflows
        do_reset();
        for (int n = 0; n < 6; n++) begin
            set_src(1, 1'b1, 50 + n, 3, 5);
            tick();
        end
        idle_inputs();
        tick();
        check("src1_only_x", 32'(x), 55);
        check("src1_only_drop", 32'(drop), 0);

        // Flush with queued pixels and drop set; same-cycle write is ignored
        for (int n = 0; n < 8; n++) begin
            set_src(0, 1'b1, n, 9, 3);
            set_src(1, 1'b1, n, 9, 4);
            tick();
        end
        flush = 1'b1;
        tick();
        check("flush_pending", 32'(pending), 0);
        check("flush_drop", 32'(drop), 0);
        check("flush_plot", 32'(plot), 0);
        idle_inputs();
        tick();
        check("flush_nowrite_plot", 32'(plot), 0);

        // Asynchronous reset with plot high
        for (int n = 0; n < 3; n++) begin
            set_src(0, 1'b1, 70 + n, 11, 6);
            set_src(1, 1'b1, 90 + n, 12, 7);
            tick();
        end
        idle_inputs();
        check("pre_areset_plot", 32'(plot), 1);
        #2;
        reset_n = 1'b0;
        #1;
        check("areset_plot", 32'(plot), 0);
        check("areset_x", 32'(x), 0);
        check("areset_y", 32'(y), 0);
        check("areset_c", 32'(colour), 0);
        check("areset_drop", 32'(drop), 0);
        check("areset_pending", 32'(pending), 0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        set_src(1, 1'b1, 33, 34, 3);
        set_src(0, 1'b1, 21, 22, 5);
        tick();
        idle_inputs();
        tick();
        check("areset_first_grant_x", 32'(x), 21);
        tick();
        check("areset_second_grant_x", 32'(x), 33);

        // Random traffic with occasional flush
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < NUM_SRC; i++)
                set_src(i, 1'($urandom_range(0, 99) < 60), $urandom, $urandom, $urandom);
            flush = ($urandom_range(0, 49) == 0);
            tick();
        end
        idle_inputs();
        for (int n = 0; n < 10; n++) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
